// File: rtl/alu_if.sv
// Operand/opcode bus into the execute-stage ALU and its registered result/flags back out.
// master drives operands and opcode; slave (the ALU) drives result and flags.
interface aluIf;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [2:0]  ALUOp;
    logic [31:0] outC;
    logic [3:0]  ALUsig;

    modport master (
        output srcA,
        output srcB,
        output ALUOp,
        input  outC,
        input  ALUsig
    );

    modport slave (
        input  srcA,
        input  srcB,
        input  ALUOp,
        output outC,
        output ALUsig
    );
endinterface

// File: rtl/alu.sv
// 32-bit MIPS execute-stage ALU: eight ops plus {V,C,N,Z} flags.
// Latency: one clk, result and flags registered together.
// Backpressure: none; a new op is accepted every cycle.
module alu (
    input logic  clk,
    input logic  reset,
    aluIf.slave  bus
);
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SLT  = 3'd5;
    localparam logic [2:0] OP_SLTU = 3'd6;
    localparam logic [2:0] OP_LUI  = 3'd7;

    logic [32:0] sumExt;
    logic [32:0] diffExt;
    logic [31:0] result;
    logic        carryFlag;
    logic        ovfFlag;

    // Extra top bit gives carry-out for ADD and borrow for SUB.
    assign sumExt  = {1'b0, bus.srcA} + {1'b0, bus.srcB};
    assign diffExt = {1'b0, bus.srcA} - {1'b0, bus.srcB};

    always_comb begin
        result    = 32'h0;
        carryFlag = 1'b0;
        ovfFlag   = 1'b0;
        case (bus.ALUOp)
            OP_ADD: begin
                result    = sumExt[31:0];
                carryFlag = sumExt[32];
                ovfFlag   = (bus.srcA[31] == bus.srcB[31]) && (sumExt[31] != bus.srcA[31]);
            end
            OP_SUB: begin
                result    = diffExt[31:0];
                carryFlag = diffExt[32];
                ovfFlag   = (bus.srcA[31] != bus.srcB[31]) && (diffExt[31] != bus.srcA[31]);
            end
            OP_OR:   result = bus.srcA | bus.srcB;
            OP_AND:  result = bus.srcA & bus.srcB;
            OP_XOR:  result = bus.srcA ^ bus.srcB;
            OP_SLT:  result = {31'b0, $signed(bus.srcA) < $signed(bus.srcB)};
            OP_SLTU: result = {31'b0, bus.srcA < bus.srcB};
            OP_LUI:  result = {bus.srcB[15:0], 16'h0000};
            default: result = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.outC   <= 32'h0;
            bus.ALUsig <= 4'h0;
        end else begin
            bus.outC   <= result;
            bus.ALUsig <= {ovfFlag, carryFlag, result[31], result == 32'h0};
        end
    end
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases then randomized ops against an arithmetic model.
module tb_alu;
    logic clk;
    logic reset;
    int   nChecks;
    int   nPass;

    aluIf bus ();

    alu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Reference: plain 64-bit integer arithmetic, overflow as out-of-range signed sum.
    function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] op,
                                     output logic [31:0] r, output logic [3:0] f);
        longint unsigned ua;
        longint unsigned ub;
        longint          sa;
        longint          sb;
        longint          t;
        logic            c;
        logic            v;
        ua = 64'(a);
        ub = 64'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        t  = 0;
        case (op)
            3'd0: begin
                r = 32'(ua + ub);
                c = (ua + ub) > 64'hFFFF_FFFF;
                t = sa + sb;
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd1: begin
                r = 32'(ua - ub);
                c = ua < ub;
                t = sa - sb;
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd2: r = a | b;
            3'd3: r = a & b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: r = (ua < ub) ? 32'd1 : 32'd0;
            default: r = {b[15:0], 16'h0000};
        endcase
        f = {v, c, r[31], r == 32'h0};
    endfunction

    // Present one op before an edge, then sample just after it.
    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic rst);
        logic [31:0] expC;
        logic [3:0]  expF;
        @(negedge clk);
        bus.srcA  = a;
        bus.srcB  = b;
        bus.ALUOp = op;
        reset     = rst;
        if (rst) begin
            expC = 32'h0;
            expF = 4'h0;
        end else begin
            refModel(a, b, op, expC, expF);
        end
        @(posedge clk);
        #1;
        checkVal({tag, ".outC"}, bus.outC, expC);
        checkVal({tag, ".flags"}, 32'(bus.ALUsig), 32'(expF));
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        nChecks   = 0;
        nPass     = 0;
        reset     = 1'b1;
        bus.srcA  = 32'h0;
        bus.srcB  = 32'h0;
        bus.ALUOp = 3'd0;

        runOp("reset", 32'h1234_5678, 32'h1111_1111, 3'd0, 1'b1);

        runOp("addWrap",  32'hFFFF_FFFF, 32'h8000_0000, 3'd0, 1'b0);
        checkVal("addWrapFlagsConst", 32'(bus.ALUsig), 32'(4'b1100));
        runOp("subNoBorrow", 32'hFFFF_FFFF, 32'h8000_0000, 3'd1, 1'b0);
        checkVal("subFlagsConst", 32'(bus.ALUsig), 32'(4'b0000));
        runOp("or",  32'hF0F0_0F00, 32'h0F0F_00F0, 3'd2, 1'b0);
        checkVal("orConst", bus.outC, 32'hFFFF_0FF0);
        runOp("and", 32'hFFFF_0F00, 32'h0F0F_FFFF, 3'd3, 1'b0);
        checkVal("andConst", bus.outC, 32'h0F0F_0F00);
        runOp("slt",  32'h8000_0000, 32'h0000_0000, 3'd5, 1'b0);
        checkVal("sltConst", bus.outC, 32'h1);
        runOp("sltu", 32'h8000_0000, 32'h0000_0000, 3'd6, 1'b0);
        checkVal("sltuConst", bus.outC, 32'h0);
        runOp("lui",  32'h8000_0000, 32'h0000_1234, 3'd7, 1'b0);
        checkVal("luiConst", bus.outC, 32'h1234_0000);
        runOp("subEqual", 32'h0000_0005, 32'h0000_0005, 3'd1, 1'b0);
        checkVal("subEqualFlagsConst", 32'(bus.ALUsig), 32'(4'b0001));
        runOp("resetOverride", 32'h0000_0005, 32'h0000_0007, 3'd0, 1'b1);
        runOp("xor",  32'hA5A5_5A5A, 32'hFFFF_0000, 3'd4, 1'b0);

        for (int i = 0; i < 400; i++) begin
            a = pickOperand();
            b = pickOperand();
            runOp($sformatf("rnd%0d", i), a, b, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 31) == 0));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
